// File: rtl/trap_controller_if.sv
// trap_controller_if: bundles the execute-stage, CSR-file and PC-redirect
// signals of the trap controller.
//   slave  modport - used by trap_controller (consumes execute/CSR inputs,
//                    drives trapped/busy/CSR write/read address/redirect)
//   master modport - used by the surrounding pipeline (or a testbench)
interface trap_controller_if #(
  parameter int XLEN = 32
);
  // execute stage -> controller
  logic            valid;
  logic [31:0]     instruction;
  logic            illegal;
  logic [XLEN-1:0] pc;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] mem_addr;
  // CSR file -> controller (combinational read)
  logic [XLEN-1:0] csr_read_data;
  // controller -> pipeline / CSR file / PC controller
  logic            trapped;
  logic            busy;
  logic            csr_write_enable;
  logic [11:0]     csr_write_address;
  logic [XLEN-1:0] csr_write_data;
  logic [11:0]     csr_read_address;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [3:0]      trap_cause;

  modport slave (
    input  valid, instruction, illegal, pc, branch_taken, branch_target,
           jump_target, mem_addr, csr_read_data,
    output trapped, busy, csr_write_enable, csr_write_address, csr_write_data,
           csr_read_address, redirect_valid, redirect_target, trap_cause
  );

  modport master (
    output valid, instruction, illegal, pc, branch_taken, branch_target,
           jump_target, mem_addr, csr_read_data,
    input  trapped, busy, csr_write_enable, csr_write_address, csr_write_data,
           csr_read_address, redirect_valid, redirect_target, trap_cause
  );
endinterface

// File: rtl/trap_controller.sv
// trap_controller: detects RV32I synchronous exceptions and MRET on the
// execute-stage instruction. A trap writes mepc, mcause, mtval (one per
// cycle) through the CSR write port and then redirects the PC to the mtvec
// base; MRET redirects the PC to mepc. The pipeline is stalled while busy.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - trap_controller_if.slave (execute inputs, CSR write/read,
//             redirect, trapped/busy/trap_cause status)
module trap_controller #(
  parameter int XLEN           = 32,
  parameter int IALIGN         = 32,
  parameter int CHECK_LS_ALIGN = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  trap_controller_if.slave    bus
);

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;
  // mtvec MODE bits are dropped; mepc loses bits below the instruction alignment
  localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(32'd3);
  localparam logic [XLEN-1:0] MEPC_MASK  = (IALIGN == 32) ? ~XLEN'(32'd3) : ~XLEN'(32'd1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_MEPC   = 3'd1,
    W_MCAUSE = 3'd2,
    W_MTVAL  = 3'd3,
    REDIRECT = 3'd4,
    R_MEPC   = 3'd5
  } state_t;

  state_t          state_r, state_next_s;
  logic            busy_r, we_r, rv_r;
  logic [11:0]     waddr_r, raddr_r;
  logic [XLEN-1:0] wdata_r, tval_r;
  logic [3:0]      trap_cause_r;

  logic            we_next_s, rv_next_s;
  logic [11:0]     waddr_next_s, raddr_next_s;
  logic [XLEN-1:0] wdata_next_s, tval_s, redirect_target_s;
  logic [3:0]      cause_s;
  logic            exc_s, mret_s, accept_s, is_system_s;
  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [11:0]     imm_s;

  function automatic logic target_misaligned(input logic [XLEN-1:0] target);
    if (IALIGN == 32) begin
      return target[1:0] != 2'b00;
    end else begin
      return target[0];
    end
  endfunction

  // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word
  function automatic logic ls_misaligned(input logic [1:0] size, input logic [XLEN-1:0] addr);
    case (size)
      2'b01:   return addr[0];
      2'b10:   return addr[1:0] != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  assign opcode_s    = bus.instruction[6:0];
  assign funct3_s    = bus.instruction[14:12];
  assign imm_s       = bus.instruction[31:20];
  assign is_system_s = (opcode_s == OP_SYSTEM) && (funct3_s == 3'b000);
  // busy already blocks new work, so acceptance only happens in IDLE
  assign accept_s    = (state_r == IDLE) && bus.valid;

  // Exception/MRET detection in priority order
  always_comb begin
    exc_s   = 1'b0;
    mret_s  = 1'b0;
    cause_s = 4'd0;
    tval_s  = '0;
    if (bus.illegal) begin
      exc_s   = 1'b1;
      cause_s = 4'd2;
      tval_s  = XLEN'(bus.instruction);
    end else if (is_system_s && imm_s == 12'h000) begin
      exc_s   = 1'b1;
      cause_s = 4'd11;
    end else if (is_system_s && imm_s == 12'h001) begin
      exc_s   = 1'b1;
      cause_s = 4'd3;
      tval_s  = bus.pc;
    end else if (is_system_s && imm_s == 12'h302) begin
      mret_s  = 1'b1;
    end else if ((opcode_s == OP_JAL || opcode_s == OP_JALR) && target_misaligned(bus.jump_target)) begin
      exc_s   = 1'b1;
      cause_s = 4'd0;
      tval_s  = bus.jump_target;
    end else if (opcode_s == OP_BRANCH && bus.branch_taken && target_misaligned(bus.branch_target)) begin
      exc_s   = 1'b1;
      cause_s = 4'd0;
      tval_s  = bus.branch_target;
    end else if (CHECK_LS_ALIGN != 0 && opcode_s == OP_LOAD && ls_misaligned(funct3_s[1:0], bus.mem_addr)) begin
      exc_s   = 1'b1;
      cause_s = 4'd4;
      tval_s  = bus.mem_addr;
    end else if (CHECK_LS_ALIGN != 0 && opcode_s == OP_STORE && ls_misaligned(funct3_s[1:0], bus.mem_addr)) begin
      exc_s   = 1'b1;
      cause_s = 4'd6;
      tval_s  = bus.mem_addr;
    end else begin
      exc_s   = 1'b0;
    end
  end

  assign bus.trapped = accept_s && (exc_s || mret_s);

  // Next-state logic of the trap/MRET sequencer
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (accept_s && exc_s) begin
          state_next_s = W_MEPC;
        end else if (accept_s && mret_s) begin
          state_next_s = R_MEPC;
        end else begin
          state_next_s = IDLE;
        end
      end
      W_MEPC:   state_next_s = W_MCAUSE;
      W_MCAUSE: state_next_s = W_MTVAL;
      W_MTVAL:  state_next_s = REDIRECT;
      REDIRECT: state_next_s = IDLE;
      R_MEPC:   state_next_s = IDLE;
      default:  state_next_s = IDLE;
    endcase
  end

  // Output values for the state being entered, so the CSR port is registered.
  // W_MEPC is only entered from IDLE, so the live pc is the one to save.
  always_comb begin
    we_next_s    = 1'b0;
    rv_next_s    = 1'b0;
    waddr_next_s = 12'h000;
    raddr_next_s = 12'h000;
    wdata_next_s = '0;
    case (state_next_s)
      W_MEPC: begin
        we_next_s    = 1'b1;
        waddr_next_s = CSR_MEPC;
        wdata_next_s = bus.pc;
      end
      W_MCAUSE: begin
        we_next_s    = 1'b1;
        waddr_next_s = CSR_MCAUSE;
        wdata_next_s = XLEN'(trap_cause_r);
      end
      W_MTVAL: begin
        we_next_s    = 1'b1;
        waddr_next_s = CSR_MTVAL;
        wdata_next_s = tval_r;
      end
      REDIRECT: begin
        rv_next_s    = 1'b1;
        raddr_next_s = CSR_MTVEC;
      end
      R_MEPC: begin
        rv_next_s    = 1'b1;
        raddr_next_s = CSR_MEPC;
      end
      default: begin
        we_next_s    = 1'b0;
      end
    endcase
  end

  // The CSR read is combinational, so the target follows the read data in the
  // same cycle the read address is presented
  always_comb begin
    redirect_target_s = '0;
    case (state_r)
      REDIRECT: redirect_target_s = bus.csr_read_data & MTVEC_MASK;
      R_MEPC:   redirect_target_s = bus.csr_read_data & MEPC_MASK;
      default:  redirect_target_s = '0;
    endcase
  end

  // State, registered outputs and latched trap cause/value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      we_r         <= 1'b0;
      rv_r         <= 1'b0;
      waddr_r      <= 12'h000;
      raddr_r      <= 12'h000;
      wdata_r      <= '0;
      tval_r       <= '0;
      trap_cause_r <= 4'd0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      we_r    <= we_next_s;
      rv_r    <= rv_next_s;
      waddr_r <= waddr_next_s;
      raddr_r <= raddr_next_s;
      wdata_r <= wdata_next_s;
      if (accept_s && exc_s) begin
        trap_cause_r <= cause_s;
        tval_r       <= tval_s;
      end
    end
  end

  assign bus.busy              = busy_r;
  assign bus.csr_write_enable  = we_r;
  assign bus.csr_write_address = waddr_r;
  assign bus.csr_write_data    = wdata_r;
  assign bus.csr_read_address  = raddr_r;
  assign bus.redirect_valid    = rv_r;
  assign bus.redirect_target   = redirect_target_s;
  assign bus.trap_cause        = trap_cause_r;

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Sequential successor to the combinational exception detector.
- Detects RV32I synchronous exceptions and MRET on the instruction in the execute stage.
- On a trap, serialises the machine-mode CSR updates mepc → mcause → mtval through the CSR file write port, then redirects the PC to mtvec. On MRET, redirects the PC to mepc.
- Parametrised in XLEN, instruction alignment and load/store misalignment checking. Sits between execute stage, CSR file and PC controller; stalls the pipeline while busy.

Parameters:
- XLEN, 32, datapath/address width.
- IALIGN, 32, instruction alignment in bits: 32 checks target[1:0], 16 checks target[0] only.
- CHECK_LS_ALIGN, 1, 1 = enable load/store misalignment exceptions; 0 = never raise causes 4/6.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- valid  in  1  execute-stage instruction valid
- instruction  in  32  raw instruction (opcode/funct3/imm decoded internally)
- illegal  in  1  decoder illegal-instruction flag
- pc  in  XLEN  PC of instruction
- branch_taken  in  1  branch resolved taken
- branch_target  in  XLEN  branch target
- jump_target  in  XLEN  JAL/JALR target
- mem_addr  in  XLEN  load/store effective address
- csr_read_data  in  XLEN  combinational CSR read data
- trapped  out  1  combinational: exception or MRET accepted this cycle; kill instruction
- busy  out  1  registered: FSM not IDLE; stall fetch/decode/execute
- csr_write_enable  out  1  CSR write strobe
- csr_write_address  out  12  CSR write address
- csr_write_data  out  XLEN  CSR write data
- csr_read_address  out  12  CSR read address
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_target  out  XLEN  new PC
- trap_cause  out  4  registered cause of last accepted trap

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy, csr_write_enable, redirect_valid=0; csr_write_address, csr_write_data, csr_read_address, redirect_target=0; trap_cause=0; latched pc/cause/tval cleared. Reset mid-sequence aborts it with no further CSR writes.
- Detection (IDLE, valid=1), priority high→low:
  - illegal: cause 2, tval=instruction
  - ECALL (opcode 1110011, funct3 000, imm 0x000): cause 11, tval=0
  - EBREAK (imm 0x001): cause 3, tval=pc
  - MRET (imm 0x302): not a trap, MRET path
  - JAL/JALR, or BRANCH with branch_taken, whose target violates IALIGN: cause 0, tval=target
  - Load (0000011) / store (0100011), CHECK_LS_ALIGN=1, misaligned per funct3 (H: addr[0]; W: addr[1:0]≠0; B/BU never): cause 4 (load) / 6 (store), tval=mem_addr
  - Untaken branch is never misaligned.
- trapped=1 combinationally in the detect cycle only when state=IDLE.
- Inputs are ignored while busy=1.
- Trap FSM: IDLE →(exception) W_MEPC → W_MCAUSE → W_MTVAL → REDIRECT → IDLE. One cycle per state.
  - W_MEPC: write 0x341 ← latched pc.
  - W_MCAUSE: write 0x342 ← zero-extended cause, MSB 0.
  - W_MTVAL: write 0x343 ← tval.
  - REDIRECT: csr_read_address=0x305; redirect_valid=1; redirect_target = mtvec with bits[1:0] cleared. Exceptions always use the base, even in vectored mode.
  - trap_cause updates in W_MEPC.
- MRET FSM: IDLE → R_MEPC → IDLE.
  - R_MEPC: csr_read_address=0x341; redirect_valid=1; redirect_target = mepc with bit0 cleared, plus bit1 cleared when IALIGN=32.
  - No CSR writes.
- Latency: exception detected at cycle T → redirect at T+4, busy high T+1..T+4. MRET at T → redirect at T+1, busy high T+1.
- csr_write_enable high only in W_* states. Address/data outputs return to 0 when not writing.
- Back-to-back: valid in the IDLE cycle immediately after REDIRECT is evaluated normally.

Test Plan:
- ECALL (0x00000073), pc=0x100, mtvec=0x200 → trapped at T. Writes 0x341←0x100 (T+1), 0x342←11 (T+2), 0x343←0 (T+3). redirect 0x200 at T+4, busy T+1..T+4.
- EBREAK (0x00100073), pc=0x80 → mcause 3, mtval 0x80. ADD (0x00000033) → trapped=0, no writes.
- JAL, jump_target=0xF2: IALIGN=32 → cause 0, mtval 0xF2. IALIGN=16 → no trap. BRANCH target 0xF1, branch_taken=0 → no trap; branch_taken=1 → cause 0.
- LW, mem_addr=0x1002 → cause 4, mtval 0x1002. SH, mem_addr=0x1001 → cause 6. LB 0x1003 → none. CHECK_LS_ALIGN=0 → none.
- MRET (0x30200073), mepc=0x404 → redirect 0x404 at T+1, no CSR write. Illegal=1 together with an ECALL encoding → cause 2, mtval=instruction.
- reset_n low during W_MCAUSE → all outputs 0 immediately, no mtval write, no redirect. Valid ECALL while busy → ignored.
